// File: rtl/csi_rx_dly_cal_pkg.sv
// Shared types and constants for the CSI-2 RX IDELAY tap calibration slice.
// The eye-centre helper picks the lower centre of a run of good taps.
package csi_rx_dly_cal_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam int         DLY_TAPS  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_APPLY,
    ST_DONE
  } cal_state_e;

  // A run of len >= 1 starting at lo never extends past tap 31, so the
  // sum always fits in five bits.
  function automatic logic [4:0] eye_centre(input logic [4:0] lo,
                                            input logic [5:0] len);
    logic [4:0] half;
    half = 5'((len - 6'd1) >> 1);
    return lo + half;
  endfunction

endpackage

// File: rtl/csi_rx_sync_hunt.sv
// Unaligned sync-byte detector: flags a SYNC_BYTE at any of the eight bit
// offsets spanning the previous and current raw bytes; output is registered.
module csi_rx_sync_hunt
  import csi_rx_dly_cal_pkg::*;
(
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  output logic       sync_hit
);

  logic [7:0]  prev_byte;
  logic [15:0] win_p0;
  logic        hit_p0;

  always_ff @(posedge byte_clock) begin
    prev_byte <= data_in;
  end

  // Offsets 0..7 only: offset 8 is the next cycle's offset 0, so no
  // occurrence is ever counted twice.
  always_comb begin
    win_p0 = {data_in, prev_byte};
    hit_p0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (win_p0[i +: 8] == SYNC_BYTE) hit_p0 = 1'b1;
    end
  end

  // Stage p0 -> p1: registered hit, one cycle behind data_in.
  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) sync_hit <= 1'b0;
    else          sync_hit <= hit_p0;
  end

endmodule

// File: rtl/csi_rx_dly_cal.sv
// IDELAY tap calibration: sweeps all taps, scores each by sync hits, finds
// the widest contiguous run of good taps and loads its lower centre.
module csi_rx_dly_cal
  import csi_rx_dly_cal_pkg::*;
#(
  parameter int SETTLE_CYC  = 8,
  parameter int WIN_LOG2    = 10,
  parameter int MIN_HITS    = 4,
  parameter int MIN_EYE     = 3,
  parameter int DEFAULT_TAP = 3
) (
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] deser_in,
  output logic       dly_ld,
  output logic [4:0] dly_cntval,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [4:0] eye_lo,
  output logic [5:0] eye_len
);

  localparam int HIT_W = WIN_LOG2 + 1;
  localparam int CNT_W = (HIT_W > 8) ? HIT_W : 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [4:0]       LAST_TAP    = 5'(DLY_TAPS - 1);
  localparam logic [4:0]       DFLT_TAP    = 5'(DEFAULT_TAP);

  function automatic logic [HIT_W-1:0] hit_sat_inc(input logic [HIT_W-1:0] v,
                                                   input logic inc);
    if (inc && (v != {HIT_W{1'b1}})) return v + HIT_W'(1);
    return v;
  endfunction

  cal_state_e       state, state_d;
  logic [4:0]       tap, tap_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [HIT_W-1:0] hit_cnt, hit_cnt_d;
  logic [5:0]       cur_len, cur_len_d, best_len, best_len_d;
  logic [4:0]       cur_lo, cur_lo_d, best_lo, best_lo_d;
  logic             fail_d, ld_d;
  logic [4:0]       cntval_d;
  logic             sync_hit;
  logic             good;
  logic [5:0]       run_len;
  logic [4:0]       run_lo;

  csi_rx_sync_hunt u_sync_hunt (
    .byte_clock (byte_clock),
    .reset_n    (reset_n),
    .data_in    (deser_in),
    .sync_hit   (sync_hit)
  );

  always_comb begin
    state_d    = state;
    tap_d      = tap;
    cnt_d      = cnt;
    hit_cnt_d  = hit_cnt;
    cur_len_d  = cur_len;
    cur_lo_d   = cur_lo;
    best_len_d = best_len;
    best_lo_d  = best_lo;
    fail_d     = fail;
    ld_d       = 1'b0;
    cntval_d   = dly_cntval;

    good    = (hit_cnt >= HIT_W'(MIN_HITS));
    run_len = good ? (cur_len + 6'd1) : 6'd0;
    run_lo  = (good && (cur_len == 6'd0)) ? tap : cur_lo;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          tap_d      = 5'd0;
          cur_len_d  = 6'd0;
          cur_lo_d   = 5'd0;
          best_len_d = 6'd0;
          best_lo_d  = 5'd0;
          fail_d     = 1'b0;
          ld_d       = 1'b1;
          cntval_d   = 5'd0;
        end
      end
      ST_LOAD: begin
        state_d   = ST_SETTLE;
        cnt_d     = '0;
        hit_cnt_d = '0;
      end
      ST_SETTLE: begin
        hit_cnt_d = '0;
        if (cnt == SETTLE_LAST) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        hit_cnt_d = hit_sat_inc(hit_cnt, sync_hit);
        if (cnt == WIN_LAST) state_d = ST_EVAL;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      ST_EVAL: begin
        cur_len_d = run_len;
        cur_lo_d  = run_lo;
        // Strictly longer only, so the lowest-tap run wins a tie.
        if (run_len > best_len) begin
          best_len_d = run_len;
          best_lo_d  = run_lo;
        end
        ld_d = 1'b1;
        if (tap == LAST_TAP) begin
          state_d = ST_APPLY;
          if (best_len_d >= 6'(MIN_EYE)) begin
            cntval_d = eye_centre(best_lo_d, best_len_d);
          end else begin
            cntval_d = DFLT_TAP;
            fail_d   = 1'b1;
          end
        end else begin
          state_d  = ST_LOAD;
          tap_d    = tap + 5'd1;
          cntval_d = tap + 5'd1;
        end
      end
      ST_APPLY: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reset abandons the sweep without issuing a reload; the IDELAY keeps its tap.
  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tap        <= 5'd0;
      cnt        <= '0;
      hit_cnt    <= '0;
      cur_len    <= 6'd0;
      cur_lo     <= 5'd0;
      best_len   <= 6'd0;
      best_lo    <= 5'd0;
      fail       <= 1'b0;
      dly_ld     <= 1'b0;
      dly_cntval <= DFLT_TAP;
    end else begin
      state      <= state_d;
      tap        <= tap_d;
      cnt        <= cnt_d;
      hit_cnt    <= hit_cnt_d;
      cur_len    <= cur_len_d;
      cur_lo     <= cur_lo_d;
      best_len   <= best_len_d;
      best_lo    <= best_lo_d;
      fail       <= fail_d;
      dly_ld     <= ld_d;
      dly_cntval <= cntval_d;
    end
  end

  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);
  assign eye_lo  = best_lo;
  assign eye_len = best_len;

endmodule

// File: tb/tb_csi_rx_dly_cal.sv
// Directed bench for csi_rx_dly_cal: per-tap hit tables drive the lane,
// expected sweep outcomes are queued at start and popped when done rises.
module tb_csi_rx_dly_cal;

  localparam int SETTLE    = 4;
  localparam int WLOG      = 6;
  localparam int SWEEP_CYC = 32 * (1 + SETTLE + (1 << WLOG) + 1) + 1;

  logic       byte_clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] deser_in;
  logic       dly_ld;
  logic [4:0] dly_cntval;
  logic       busy;
  logic       done;
  logic       fail;
  logic [4:0] eye_lo;
  logic [5:0] eye_len;

  int errors = 0;
  int checks = 0;
  int hits_tbl [32];

  typedef struct {
    logic       fail;
    logic [4:0] lo;
    logic [5:0] len;
    logic [4:0] load;
  } exp_t;
  exp_t sb_q [$];

  int         ld_cnt = 0;
  int         ld_double = 0;
  logic [4:0] last_ld_val = 5'd0;
  logic [4:0] first_ld_val = 5'd0;
  bit         first_seen = 1'b0;
  bit         prev_ld = 1'b0;

  csi_rx_dly_cal #(
    .SETTLE_CYC  (SETTLE),
    .WIN_LOG2    (WLOG),
    .MIN_HITS    (4),
    .MIN_EYE     (3),
    .DEFAULT_TAP (3)
  ) dut (
    .byte_clock (byte_clock),
    .reset_n    (reset_n),
    .start      (start),
    .deser_in   (deser_in),
    .dly_ld     (dly_ld),
    .dly_cntval (dly_cntval),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .eye_lo     (eye_lo),
    .eye_len    (eye_len)
  );

  always #5 byte_clock = ~byte_clock;

  // Load-strobe monitor: counts loads since the last accepted start.
  always @(negedge byte_clock) begin
    if (start && !busy) begin
      ld_cnt     <= 0;
      ld_double  <= 0;
      first_seen <= 1'b0;
    end else if (dly_ld) begin
      if (prev_ld) ld_double <= ld_double + 1;
      ld_cnt      <= ld_cnt + 1;
      last_ld_val <= dly_cntval;
      if (!first_seen) begin
        first_ld_val <= dly_cntval;
        first_seen   <= 1'b1;
      end
    end
    prev_ld <= dly_ld;
  end

  // Lane model: after each load, emit hits_tbl[tap] sync bytes at bit
  // offset 3 (C0 then 05), 16 cycles apart, all inside the measure window.
  initial begin
    int c;
    int k;
    deser_in = 8'h00;
    c = 1000;
    k = 0;
    forever begin
      @(negedge byte_clock);
      if (dly_ld) begin
        c = 0;
        k = hits_tbl[dly_cntval];
      end else begin
        c++;
      end
      deser_in = 8'h00;
      for (int j = 0; j < k; j++) begin
        if (c == 9 + 16 * j)  deser_in = 8'hC0;
        if (c == 10 + 16 * j) deser_in = 8'h05;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tbl();
    for (int t = 0; t < 32; t++) hits_tbl[t] = 0;
  endtask

  task automatic set_rng(input int lo, input int hi, input int k);
    for (int t = lo; t <= hi; t++) hits_tbl[t] = k;
  endtask

  task automatic push_exp(input logic f, input int lo, input int len, input int load);
    exp_t e;
    e.fail = f;
    e.lo   = 5'(lo);
    e.len  = 6'(len);
    e.load = 5'(load);
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge byte_clock); #1 start = 1'b1;
    @(posedge byte_clock); #1 start = 1'b0;
  endtask

  task automatic run_sweep(input string name, input bit mid_start);
    int   busy_cyc;
    int   guard;
    exp_t e;
    pulse_start();
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_done_after_start"}, done, 0);
    busy_cyc = 0;
    guard    = 0;
    while (!done && guard < SWEEP_CYC + 200) begin
      if (busy) busy_cyc++;
      start = (mid_start && guard == 100);
      @(posedge byte_clock); #1;
      guard++;
    end
    start = 1'b0;
    check({name, "_done_reached"}, done, 1);
    check({name, "_sweep_cycles"}, busy_cyc, SWEEP_CYC);
    check({name, "_busy_at_done"}, busy, 0);
    if (sb_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({name, "_fail"},       fail,        e.fail);
      check({name, "_eye_lo"},     eye_lo,      e.lo);
      check({name, "_eye_len"},    eye_len,     e.len);
      check({name, "_final_load"}, last_ld_val, e.load);
      check({name, "_cntval_held"}, dly_cntval, e.load);
    end
    check({name, "_ld_count"},   ld_cnt,       33);
    check({name, "_first_tap"},  first_ld_val, 0);
    check({name, "_ld_double"},  ld_double,    0);
  endtask

  initial begin
    int guard;
    reset_n = 1'b1;
    start   = 1'b0;
    clear_tbl();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge byte_clock);
    #1;
    check("rst_dly_ld",  dly_ld,     0);
    check("rst_cntval",  dly_cntval, 3);
    check("rst_busy",    busy,       0);
    check("rst_done",    done,       0);
    check("rst_fail",    fail,       0);
    check("rst_eye_lo",  eye_lo,     0);
    check("rst_eye_len", eye_len,    0);
    reset_n = 1'b1;
    repeat (3) @(posedge byte_clock);
    #1;
    check("idle_busy",   busy,   0);
    check("idle_dly_ld", dly_ld, 0);

    // Eye in the middle, with a start pulse mid-sweep that must be ignored.
    clear_tbl();
    set_rng(10, 17, 4);
    push_exp(1'b0, 10, 8, 13);
    run_sweep("mid_eye", 1'b1);

    // No sync at all; also a restart straight from DONE.
    clear_tbl();
    push_exp(1'b1, 0, 0, 3);
    run_sweep("no_sync", 1'b0);

    // Two equal runs: the lower one wins.
    clear_tbl();
    set_rng(2, 5, 4);
    set_rng(20, 23, 4);
    push_exp(1'b0, 2, 4, 3);
    run_sweep("tie", 1'b0);

    // Run still open at tap 31.
    clear_tbl();
    set_rng(28, 31, 4);
    push_exp(1'b0, 28, 4, 29);
    run_sweep("top_run", 1'b0);

    // Three hits is bad, four is good.
    clear_tbl();
    set_rng(9, 9, 3);
    set_rng(10, 14, 4);
    set_rng(15, 15, 3);
    set_rng(16, 17, 4);
    push_exp(1'b0, 10, 5, 12);
    run_sweep("threshold", 1'b0);

    // Reset during MEASURE at tap 7.
    clear_tbl();
    set_rng(2, 5, 4);
    pulse_start();
    guard = 0;
    while (!(dly_ld && dly_cntval == 5'd7) && guard < 1000) begin
      @(posedge byte_clock); #1;
      guard++;
    end
    check("rstmid_tap7_seen", (guard < 1000), 1);
    repeat (20) @(posedge byte_clock);
    #1;
    check("rstmid_busy_before", busy,    1);
    check("rstmid_len_before",  eye_len, 4);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_dly_ld",  dly_ld,     0);
    check("rstmid_cntval",  dly_cntval, 3);
    check("rstmid_busy",    busy,       0);
    check("rstmid_done",    done,       0);
    check("rstmid_eye_lo",  eye_lo,     0);
    check("rstmid_eye_len", eye_len,    0);
    repeat (5) @(posedge byte_clock);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge byte_clock);
    #1;
    check("rstmid_no_reload", ld_cnt,     8);
    check("rstmid_idle_busy", busy,       0);
    check("rstmid_idle_done", done,       0);
    check("rstmid_idle_cnt",  dly_cntval, 3);

    // Fresh sweep from IDLE after the aborted one.
    clear_tbl();
    set_rng(10, 17, 4);
    push_exp(1'b0, 10, 8, 13);
    run_sweep("after_reset", 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csi_rx_dly_cal.md
# csi_rx_dly_cal

Per-lane IDELAY tap calibration controller for the CSI-2 D-PHY data lane. It sweeps all 32 IDELAY taps of one lane through the VAR_LOAD interface and scores each tap by counting sync-byte hits in the raw deserialised bytes. It then locates the widest contiguous run of good taps and loads the centre of that run. It sits beside `csi_rx_phy_dat` in the byte-clock domain and drives the delay element's `LD` and `CNTVALUEIN`, replacing the fixed DELAY load.

## Interface

Parameters:
- `SETTLE_CYC`, default 8: byte clocks waited after each tap load before measuring (1..255).
- `WIN_LOG2`, default 10: measurement window per tap is 2^WIN_LOG2 byte clocks.
- `MIN_HITS`, default 4: minimum sync hits in a window for a tap to count as good.
- `MIN_EYE`, default 3: minimum good-run length for a pass.
- `DEFAULT_TAP`, default 3: tap loaded on failure.

Ports:
- Clocking and reset: one clock, `byte_clock`. Reset is `reset_n`, asynchronous and active-low.
- `byte_clock`, in, 1: byte clock, the same clock that drives ISERDES CLKDIV and IDELAY C.
- `reset_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle pulse that starts a calibration; ignored while `busy`=1.
- `deser_in`, in, 8: raw unaligned byte from the lane deserialiser; bit 7 is the most recent bit.
- `dly_ld`, out, 1: one-cycle load strobe to IDELAY `LD`.
- `dly_cntval`, out, 5: tap value to IDELAY `CNTVALUEIN`; held stable outside loads.
- `busy`, out, 1: calibration in progress.
- `done`, out, 1: level signal meaning calibration finished; cleared by the next accepted `start`.
- `fail`, out, 1: valid when `done`=1; set when no eye of at least MIN_EYE taps was found.
- `eye_lo`, out, 5: first tap of the best run; valid when `done`=1.
- `eye_len`, out, 6: length of the best run (0..32); valid when `done`=1.

## Operation

States are IDLE, LOAD, SETTLE, MEASURE, EVAL, APPLY and DONE.

- **IDLE:** on `start`, go to LOAD with `tap`=0; clear the run trackers and `fail`; set `busy`.
- **LOAD:** lasts 1 cycle. `dly_ld`=1 and `dly_cntval`=`tap`. Then go to SETTLE.
- **SETTLE:** lasts SETTLE_CYC cycles. Hits are not counted. Then go to MEASURE.
- **MEASURE:** lasts 2^WIN_LOG2 cycles. `hit_cnt` counts cycles with `sync_hit`=1. `hit_cnt` is WIN_LOG2+1 bits wide and saturating. Then go to EVAL.
- **EVAL:** lasts 1 cycle. `good` = (`hit_cnt` >= MIN_HITS).
  - If `good`: `cur_len`+1, and `cur_lo`=`tap` when `cur_len` was 0.
  - If not `good`: `cur_len`=0.
  - The updated run is compared with the best run. It replaces best only if strictly longer, so on a tie the lowest-tap run wins.
  - A run still open at tap 31 is therefore evaluated on that tap.
  - If `tap`=31, go to APPLY. Otherwise `tap`+1 and go to LOAD.
- **APPLY:** lasts 1 cycle. `dly_ld`=1.
  - If `best_len` >= MIN_EYE: `dly_cntval` = `best_lo` + ((`best_len`-1)>>1), i.e. the lower centre. This value cannot exceed 31.
  - Otherwise: `dly_cntval`=DEFAULT_TAP and `fail`=1.
  - Then go to DONE.
- **DONE:** `done`=1 and `busy`=0. On `start`, go to LOAD (same actions as from IDLE); `done` drops in the same cycle.

**Sync detect.** Form w = {`deser_in`, `prev_byte`}, 16 bits, where `prev_byte` is registered every cycle. `sync_hit` is registered and is 1 when w[i+7:i] == SYNC_BYTE for any i in 0..7. A hit at i=0 and one at i=8 cannot both be counted twice, because only offsets 0..7 are checked.

## Timing

- **Reset values:**
  - `dly_ld`=0, `dly_cntval`=DEFAULT_TAP.
  - `busy`=0, `done`=0, `fail`=0, `eye_lo`=0, `eye_len`=0.
  - State is IDLE.
- **Reset mid-sweep:** abort immediately and take the reset values. No reload is issued; the IDELAY keeps whatever tap was last loaded.
- **Start latency:** `busy` rises the cycle after `start` is sampled.
- **Sweep length:** 32 × (1 + SETTLE_CYC + 2^WIN_LOG2 + 1) cycles, plus 1 cycle for APPLY.
- **Completion:** `done` rises the cycle after APPLY.
- **Pipeline alignment:** `sync_hit` lags `deser_in` by 1 cycle. MEASURE begins counting 1 cycle after entering the state, so the window covers exactly 2^WIN_LOG2 samples.
- **`dly_ld`:** never high for more than 1 cycle.

## Structure

- `top_pkg` gains:
  - `SYNC_BYTE` = 8'hB8
  - `DLY_TAPS` = 32
  - `typedef enum logic [2:0]` for the states
- Sub-module `csi_rx_sync_hunt`: holds the `prev_byte` register, the 8-offset comparator and the registered `sync_hit`. It is reusable by the word aligner.

## Test plan

1. **Eye in the middle:** drive 0xB8 at offset 3 every 16 cycles only while `dly_cntval` is in 10..17, otherwise 0x00 → `eye_lo`=10, `eye_len`=8, final load 13, `fail`=0.
2. **No sync at all:** → `fail`=1, `eye_len`=0, final `dly_cntval`=3.
3. **Two runs of equal width:** runs 2..5 and 20..23 → `eye_lo`=2, final load 3.
4. **Run touching tap 31:** run 28..31 → `eye_len`=4, final load 29.
5. **Threshold boundary:** with MIN_HITS=4, a tap seeing exactly 3 hits is bad and a tap seeing exactly 4 is good.
6. **Reset and start handling:**
   - `reset_n` low during MEASURE at tap 7 → outputs take reset values with no `dly_ld` pulse.
   - `start` during `busy` is ignored.
   - `start` in DONE restarts at tap 0 with `done` cleared.
